// File: rtl/fb_write_arbiter.sv
// Frame-buffer write-port arbiter: the camera stream has priority over overlay writes,
// and a clear sequencer fills the whole buffer with one colour.
module fb_write_arbiter #(
  parameter int FB_DEPTH = 76800
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cam_valid,
  input  logic [16:0] cam_addr,
  input  logic [15:0] cam_data,
  input  logic        ovl_req,
  input  logic [16:0] ovl_addr,
  input  logic [15:0] ovl_data,
  output logic        ovl_ack,
  input  logic        clr_start,
  input  logic [15:0] clr_color,
  output logic        clr_busy,
  output logic        clr_done,
  output logic        cam_drop,
  output logic        fb_we,
  output logic [16:0] fb_wAddr,
  output logic [15:0] fb_wData
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // The extra top bit keeps the range check exact for any depth that fits 17 bits.
  localparam logic [17:0] DEPTH_EXT = 18'(FB_DEPTH);
  localparam logic [16:0] LAST_ADDR = 17'(FB_DEPTH - 1);

  state_t      state_r, state_s;
  logic [16:0] cnt_r, cnt_s;
  logic [15:0] color_r, color_s;
  logic        we_r, we_s;
  logic [16:0] waddr_r, waddr_s;
  logic [15:0] wdata_r, wdata_s;
  logic        busy_r, busy_s;
  logic        done_r, done_s;
  logic        drop_r, drop_s;
  logic        ovl_ack_s;
  logic        cam_in_range_s;
  logic        ovl_in_range_s;

  assign cam_in_range_s = ({1'b0, cam_addr} < DEPTH_EXT);
  assign ovl_in_range_s = ({1'b0, ovl_addr} < DEPTH_EXT);

  // A clear request in the same cycle blocks the overlay, since the overlay slot is about to vanish.
  assign ovl_ack_s = reset_n & ovl_req & (state_r == IDLE) & ~cam_valid & ~clr_start;
  assign ovl_ack   = ovl_ack_s;

  // Next-state and next-output decode for the arbitration/clear FSM.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    color_s = color_r;
    we_s    = 1'b0;
    waddr_s = waddr_r;
    wdata_s = wdata_r;
    busy_s  = 1'b0;
    done_s  = 1'b0;
    drop_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (cam_valid) begin
          if (cam_in_range_s) begin
            we_s    = 1'b1;
            waddr_s = cam_addr;
            wdata_s = cam_data;
          end else begin
            drop_s  = 1'b1;
          end
        end else if (ovl_ack_s) begin
          if (ovl_in_range_s) begin
            we_s    = 1'b1;
            waddr_s = ovl_addr;
            wdata_s = ovl_data;
          end else begin
            we_s    = 1'b0;
          end
        end else begin
          we_s = 1'b0;
        end
        if (clr_start) begin
          state_s = CLEAR;
          cnt_s   = 17'd0;
          color_s = clr_color;
        end else begin
          state_s = IDLE;
        end
      end
      CLEAR: begin
        we_s    = 1'b1;
        waddr_s = cnt_r;
        wdata_s = color_r;
        busy_s  = 1'b1;
        drop_s  = cam_valid;
        if (cnt_r == LAST_ADDR) begin
          done_s  = 1'b1;
          state_s = IDLE;
          cnt_s   = 17'd0;
        end else begin
          state_s = CLEAR;
          cnt_s   = cnt_r + 17'd1;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 17'd0;
      end
    endcase
  end

  // State, clear bookkeeping and registered write-port outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      cnt_r   <= 17'd0;
      color_r <= 16'd0;
      we_r    <= 1'b0;
      waddr_r <= 17'd0;
      wdata_r <= 16'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      drop_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      color_r <= color_s;
      we_r    <= we_s;
      waddr_r <= waddr_s;
      wdata_r <= wdata_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      drop_r  <= drop_s;
    end
  end

  assign fb_we    = we_r;
  assign fb_wAddr = waddr_r;
  assign fb_wData = wdata_r;
  assign clr_busy = busy_r;
  assign clr_done = done_r;
  assign cam_drop = drop_r;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench: arbitration vectors on a full-size instance, clear and reset-abort
// sequences on a 16-word instance.
module tb_fb_write_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cam_valid;
  logic [16:0] cam_addr;
  logic [15:0] cam_data;
  logic        ovl_req;
  logic [16:0] ovl_addr;
  logic [15:0] ovl_data;
  logic        clr_start_a, clr_start_b;
  logic [15:0] clr_color;

  logic        ack_a, busy_a, done_a, drop_a, we_a;
  logic [16:0] addr_a;
  logic [15:0] data_a;
  logic        ack_b, busy_b, done_b, drop_b, we_b;
  logic [16:0] addr_b;
  logic [15:0] data_b;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fb_write_arbiter dut_a (
    .clk(clk), .reset_n(reset_n),
    .cam_valid(cam_valid), .cam_addr(cam_addr), .cam_data(cam_data),
    .ovl_req(ovl_req), .ovl_addr(ovl_addr), .ovl_data(ovl_data), .ovl_ack(ack_a),
    .clr_start(clr_start_a), .clr_color(clr_color),
    .clr_busy(busy_a), .clr_done(done_a), .cam_drop(drop_a),
    .fb_we(we_a), .fb_wAddr(addr_a), .fb_wData(data_a)
  );

  fb_write_arbiter #(.FB_DEPTH(16)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .cam_valid(cam_valid), .cam_addr(cam_addr), .cam_data(cam_data),
    .ovl_req(ovl_req), .ovl_addr(ovl_addr), .ovl_data(ovl_data), .ovl_ack(ack_b),
    .clr_start(clr_start_b), .clr_color(clr_color),
    .clr_busy(busy_b), .clr_done(done_b), .cam_drop(drop_b),
    .fb_we(we_b), .fb_wAddr(addr_b), .fb_wData(data_b)
  );

  typedef struct {
    logic        cam_valid;
    logic [16:0] cam_addr;
    logic [15:0] cam_data;
    logic        ovl_req;
    logic [16:0] ovl_addr;
    logic [15:0] ovl_data;
    logic        exp_ack;
    logic        exp_we;
    logic [16:0] exp_addr;
    logic [15:0] exp_data;
    logic        exp_drop;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    cam_valid = 1'b0; cam_addr = 17'd0; cam_data = 16'h0000;
    ovl_req   = 1'b0; ovl_addr = 17'd0; ovl_data = 16'h0000;
  endtask

  initial begin
    int   found;
    int   done_cnt;
    int   busy_cnt;

    // cam_valid cam_addr cam_data ovl_req ovl_addr ovl_data | ack we addr data drop
    vecs[0]  = '{1'b1, 17'd100,    16'hF800, 1'b0, 17'd0,     16'h0000, 1'b0, 1'b1, 17'd100,   16'hF800, 1'b0};
    vecs[1]  = '{1'b1, 17'd200,    16'h07E0, 1'b1, 17'd300,   16'h001F, 1'b0, 1'b1, 17'd200,   16'h07E0, 1'b0};
    vecs[2]  = '{1'b0, 17'd0,      16'h0000, 1'b1, 17'd300,   16'h001F, 1'b1, 1'b1, 17'd300,   16'h001F, 1'b0};
    vecs[3]  = '{1'b0, 17'd0,      16'h0000, 1'b0, 17'd0,     16'h0000, 1'b0, 1'b0, 17'd300,   16'h001F, 1'b0};
    vecs[4]  = '{1'b1, 17'd76800,  16'h1234, 1'b0, 17'd0,     16'h0000, 1'b0, 1'b0, 17'd300,   16'h001F, 1'b1};
    vecs[5]  = '{1'b1, 17'd76799,  16'hABCD, 1'b0, 17'd0,     16'h0000, 1'b0, 1'b1, 17'd76799, 16'hABCD, 1'b0};
    vecs[6]  = '{1'b0, 17'd0,      16'h0000, 1'b1, 17'd76800, 16'h5555, 1'b1, 1'b0, 17'd76799, 16'hABCD, 1'b0};
    vecs[7]  = '{1'b0, 17'd0,      16'h0000, 1'b1, 17'd5,     16'h0F0F, 1'b1, 1'b1, 17'd5,     16'h0F0F, 1'b0};
    vecs[8]  = '{1'b0, 17'd0,      16'h0000, 1'b1, 17'd6,     16'hF0F0, 1'b1, 1'b1, 17'd6,     16'hF0F0, 1'b0};
    vecs[9]  = '{1'b1, 17'd131071, 16'hFFFF, 1'b1, 17'd7,     16'h7777, 1'b0, 1'b0, 17'd6,     16'hF0F0, 1'b1};
    vecs[10] = '{1'b0, 17'd0,      16'h0000, 1'b1, 17'd7,     16'h7777, 1'b1, 1'b1, 17'd7,     16'h7777, 1'b0};
    vecs[11] = '{1'b1, 17'd0,      16'h0000, 1'b0, 17'd0,     16'h0000, 1'b0, 1'b1, 17'd0,     16'h0000, 1'b0};

    reset_n = 1'b0;
    idle_inputs();
    ovl_req = 1'b1;
    clr_start_a = 1'b0; clr_start_b = 1'b0; clr_color = 16'h0000;

    #3;
    chk("rst_ack_a", 32'(ack_a), 32'd0);
    chk("rst_ack_b", 32'(ack_b), 32'd0);
    chk("rst_we",    32'(we_a), 32'd0);
    chk("rst_addr",  32'(addr_a), 32'd0);
    chk("rst_data",  32'(data_a), 32'd0);
    chk("rst_flags", 32'({busy_a, done_a, drop_a}), 32'd0);

    @(negedge clk);
    reset_n = 1'b1;
    ovl_req = 1'b0;

    // Arbitration table on the full-size instance.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      cam_valid = vecs[i].cam_valid; cam_addr = vecs[i].cam_addr; cam_data = vecs[i].cam_data;
      ovl_req   = vecs[i].ovl_req;   ovl_addr = vecs[i].ovl_addr; ovl_data = vecs[i].ovl_data;
      #1;
      chk($sformatf("v%0d_ack", i), 32'(ack_a), 32'(vecs[i].exp_ack));
      @(posedge clk); #1;
      chk($sformatf("v%0d_we", i),   32'(we_a),   32'(vecs[i].exp_we));
      chk($sformatf("v%0d_addr", i), 32'(addr_a), 32'(vecs[i].exp_addr));
      chk($sformatf("v%0d_data", i), 32'(data_a), 32'(vecs[i].exp_data));
      chk($sformatf("v%0d_drop", i), 32'(drop_a), 32'(vecs[i].exp_drop));
    end

    // Clear start with a concurrent camera pixel and overlay request.
    @(negedge clk);
    clr_start_b = 1'b1; clr_color = 16'h001F;
    cam_valid = 1'b1; cam_addr = 17'd3; cam_data = 16'hAAAA;
    ovl_req = 1'b1; ovl_addr = 17'd9; ovl_data = 16'h9999;
    #1;
    chk("clr_start_ack", 32'(ack_b), 32'd0);
    @(posedge clk); #1;
    chk("clr_cam_we",   32'(we_b),   32'd1);
    chk("clr_cam_addr", 32'(addr_b), 32'd3);
    chk("clr_cam_data", 32'(data_b), 32'h0000AAAA);
    chk("clr_cam_busy", 32'(busy_b), 32'd0);

    @(negedge clk);
    clr_start_b = 1'b0;
    cam_addr = 17'd4; cam_data = 16'hBBBB;
    #1;
    chk("clr_ovl_ack", 32'(ack_b), 32'd0);
    @(posedge clk); #1;
    chk("clr0_we",   32'(we_b),   32'd1);
    chk("clr0_addr", 32'(addr_b), 32'd0);
    chk("clr0_data", 32'(data_b), 32'h001F);
    chk("clr0_busy", 32'(busy_b), 32'd1);
    chk("clr0_drop", 32'(drop_b), 32'd1);
    chk("clr0_done", 32'(done_b), 32'd0);

    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      idle_inputs();
      clr_start_b = (i == 5) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
      chk($sformatf("clr%0d_we", i),   32'(we_b),   32'd1);
      chk($sformatf("clr%0d_addr", i), 32'(addr_b), 32'(i));
      chk($sformatf("clr%0d_data", i), 32'(data_b), 32'h001F);
      chk($sformatf("clr%0d_busy", i), 32'(busy_b), 32'd1);
      chk($sformatf("clr%0d_drop", i), 32'(drop_b), 32'd0);
      chk($sformatf("clr%0d_done", i), 32'(done_b), (i == 15) ? 32'd1 : 32'd0);
    end

    @(negedge clk);
    clr_start_b = 1'b0;
    @(posedge clk); #1;
    chk("clr_end_we",   32'(we_b),   32'd0);
    chk("clr_end_busy", 32'(busy_b), 32'd0);
    chk("clr_end_done", 32'(done_b), 32'd0);

    // Arbitration is back: overlay accepted after the clear.
    @(negedge clk);
    ovl_req = 1'b1; ovl_addr = 17'd12; ovl_data = 16'h4321;
    #1;
    chk("post_clr_ack", 32'(ack_b), 32'd1);
    @(posedge clk); #1;
    chk("post_clr_addr", 32'(addr_b), 32'd12);
    chk("post_clr_we",   32'(we_b),   32'd1);

    // Reset in the middle of a clear.
    @(negedge clk);
    idle_inputs();
    clr_start_b = 1'b1; clr_color = 16'h07E0;
    @(negedge clk);
    clr_start_b = 1'b0;
    found = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (we_b && busy_b && addr_b == 17'd5) begin
        found = 1;
        break;
      end
    end
    chk("abort_reach5", 32'(found), 32'd1);
    ovl_req = 1'b1; ovl_addr = 17'd2;
    #2 reset_n = 1'b0;
    #1;
    chk("abort_we",    32'(we_b),   32'd0);
    chk("abort_addr",  32'(addr_b), 32'd0);
    chk("abort_data",  32'(data_b), 32'd0);
    chk("abort_flags", 32'({busy_b, done_b, drop_b}), 32'd0);
    chk("abort_ack",   32'(ack_b),  32'd0);

    @(negedge clk);
    reset_n = 1'b1;
    ovl_req = 1'b0;
    done_cnt = 0;
    busy_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (done_b) done_cnt++;
      if (busy_b) busy_cnt++;
    end
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    chk("abort_no_busy", 32'(busy_cnt), 32'd0);

    @(negedge clk);
    cam_valid = 1'b1; cam_addr = 17'd6; cam_data = 16'h1357;
    @(posedge clk); #1;
    chk("resume_we_b",   32'(we_b),   32'd1);
    chk("resume_addr_b", 32'(addr_b), 32'd6);
    chk("resume_data_b", 32'(data_b), 32'h1357);
    chk("resume_we_a",   32'(we_a),   32'd1);

    @(negedge clk);
    idle_inputs();
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fb_write_arbiter.md
FB_WRITE_ARBITER -- requirements
Module: fb_write_arbiter

Interface
REQ-001 The block SHALL have parameter FB_DEPTH, default 76800 (320x240), meaning the number of frame-buffer words (valid addresses 0..FB_DEPTH-1).
REQ-002 The block SHALL have ports: clk  in  1  system clock, all logic rising-edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 cam_valid  in  1  camera pixel present this cycle; no backpressure.
REQ-005 cam_addr  in  17  camera pixel address.
REQ-006 cam_data  in  16  camera pixel, RGB565.
REQ-007 ovl_req  in  1  overlay write request; held with stable ovl_addr/ovl_data until acked.
REQ-008 ovl_addr  in  17  overlay write address.
REQ-009 ovl_data  in  16  overlay write data.
REQ-010 ovl_ack  out  1  combinational grant; the overlay word is accepted in the cycle ovl_ack=1.
REQ-011 clr_start  in  1  single-cycle request to fill the whole buffer.
REQ-012 clr_color  in  16  fill value, sampled with clr_start.
REQ-013 clr_busy  out  1  registered; high while a clear is in progress.
REQ-014 clr_done  out  1  registered one-cycle pulse at clear completion.
REQ-015 cam_drop  out  1  registered one-cycle pulse per discarded camera pixel.
REQ-016 fb_we  out  1  registered write enable to the frame buffer write port.
REQ-017 fb_wAddr  out  17  registered write address.
REQ-018 fb_wData  out  16  registered write data.

Function
REQ-019 The block SHALL be a two-state FSM: IDLE (arbitrate camera/overlay) and CLEAR (sequential fill).
REQ-020 In IDLE, a camera pixel with cam_valid=1 and cam_addr<FB_DEPTH SHALL be issued as fb_we=1, fb_wAddr=cam_addr, fb_wData=cam_data on the next cycle (latency 1).
REQ-021 In IDLE, a camera pixel with cam_addr>=FB_DEPTH SHALL NOT be written and SHALL produce cam_drop=1 on the next cycle.
REQ-022 ovl_ack SHALL equal ovl_req AND state=IDLE AND NOT cam_valid; camera always has priority over overlay.
REQ-023 An acked overlay word SHALL be issued on the next cycle with fb_wAddr=ovl_addr, fb_wData=ovl_data; an overlay address >=FB_DEPTH SHALL be acked and discarded (fb_we=0).
REQ-024 ovl_req held high after ovl_ack SHALL be treated as a new request.
REQ-025 When no write is issued, fb_we SHALL be 0; fb_wAddr/fb_wData SHALL hold their last values.
REQ-026 clr_start=1 in IDLE SHALL latch clr_color and enter CLEAR at the next edge; a camera pixel in the same cycle SHALL still be written per REQ-020; an overlay request in the same cycle SHALL NOT be acked.
REQ-027 In CLEAR the block SHALL issue exactly FB_DEPTH writes on consecutive cycles, addresses 0,1,..,FB_DEPTH-1, data = latched clr_color.
REQ-028 clr_busy SHALL be 1 in every cycle fb_we carries a clear write and 0 otherwise.
REQ-029 clr_done SHALL pulse in the same cycle as the write to address FB_DEPTH-1; the FSM SHALL return to IDLE so arbitration resumes on the following cycle.
REQ-030 In CLEAR, clr_start SHALL be ignored, ovl_ack SHALL be 0, and every cam_valid=1 SHALL produce a cam_drop pulse on the next cycle.
REQ-031 The clear address counter SHALL be 17 bits and SHALL not wrap; the terminal count is FB_DEPTH-1.

Reset
REQ-032 On reset_n=0, asynchronously: state=IDLE, clear counter=0, latched colour=0, fb_we=0, fb_wAddr=0, fb_wData=0, clr_busy=0, clr_done=0, cam_drop=0; a clear in progress SHALL be abandoned with no clr_done.
REQ-033 ovl_ack SHALL be 0 while reset_n=0.

Verification
REQ-034 cam_valid=1, cam_addr=100, cam_data=16'hF800 -> next cycle fb_we=1, fb_wAddr=100, fb_wData=16'hF800.
REQ-035 cam_valid=1 and ovl_req=1 same cycle -> ovl_ack=0, camera written; next cycle with cam_valid=0 -> ovl_ack=1, overlay written one cycle later.
REQ-036 clr_start=1, clr_color=16'h001F (FB_DEPTH=16) -> 16 consecutive writes, addresses 0..15, data 16'h001F, clr_done high with address 15, clr_busy high for exactly 16 cycles.
REQ-037 cam_valid=1 during CLEAR, and cam_addr=76800 in IDLE -> cam_drop pulse one cycle later, no camera write issued.
REQ-038 reset_n=0 at clear address 5 -> all outputs 0 immediately; after release, no clr_done and normal camera writes resume.
